// File: rtl/pooling_pkg.sv
// pooling_pkg
// Shared definitions for the streaming pooling unit: lane width, the
// max/min mode encoding and the fp32 total-order comparison used by every
// select element.
package pooling_pkg;

   localparam int DATA_WIDTH = 32;

   typedef enum logic {
      POOL_MAX = 1'b0,
      POOL_MIN = 1'b1
   } pool_mode_e;

   // Total order on raw fp32 bit patterns: sign-magnitude, so every negative
   // value sorts below every positive one and -0 < +0. NaNs are not special;
   // they simply order by their bit pattern like any other value.
   function automatic logic fp32_lt(input logic [DATA_WIDTH-1:0] a,
                                    input logic [DATA_WIDTH-1:0] b);
      logic res;
      if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) begin
         res = a[DATA_WIDTH-1];
      end else if (a[DATA_WIDTH-1]) begin
         res = (a[DATA_WIDTH-2:0] > b[DATA_WIDTH-2:0]);
      end else begin
         res = (a[DATA_WIDTH-2:0] < b[DATA_WIDTH-2:0]);
      end
      return res;
   endfunction

endpackage

// File: rtl/pooling_sel2.sv
// pooling_sel2
// Combinational two-input fp32 select. Returns the larger (POOL_MAX) or the
// smaller (POOL_MIN) operand under the fp32 total order. The result is always
// a bit-exact copy of one operand.
//   mode_i : select direction
//   a_i    : first operand
//   b_i    : second operand
//   y_o    : selected operand
module pooling_sel2
   import pooling_pkg::*;
(
   input  pool_mode_e            mode_i,
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   output logic [DATA_WIDTH-1:0] y_o
);

   logic a_lt_b;

   assign a_lt_b = fp32_lt(a_i, b_i);

   // On equal operands either choice is the same bit pattern.
   always_comb begin
      y_o = a_i;
      if (mode_i == POOL_MAX) begin
         y_o = a_lt_b ? b_i : a_i;
      end else begin
         y_o = a_lt_b ? a_i : b_i;
      end
   end

endmodule

// File: rtl/pooling_stream_unit.sv
// pooling_stream_unit
// Streaming KxK max/min pooling (stride K). One feature-map row of
// INPUT_SIZE fp32 lanes arrives per beat; every K input lanes are reduced
// horizontally into one column, and K consecutive rows are reduced vertically
// into one pooled output row. in_last closes a window early (partial result).
//   clk, rst_n   : clock, synchronous active-low reset
//   mode         : 0 = max, 1 = min; latched on the first row of a window
//   in_valid/in_ready/in_last/data_in : input row stream, lane 0 in MSBs
//   out_valid/out_ready/out_partial/data_out : pooled row stream
//
// Control is implicit in row_cnt_q and out_valid_q:
//   state                      | meaning
//   row_cnt_q=0                | idle / waiting for first row of a window
//   row_cnt_q=1..K-1           | window open, acc_q holds rows seen so far
//   out_valid_q=1, !out_ready  | result stalled, input stalled too
//   out_valid_q=1,  out_ready  | result leaving, input may close next window
// KERNEL_SIZE is legal in 2..4.
module pooling_stream_unit
   import pooling_pkg::*;
#(
   parameter  int OUTPUT_SIZE = 3,
   parameter  int KERNEL_SIZE = 2,
   localparam int INPUT_SIZE  = OUTPUT_SIZE * KERNEL_SIZE
)(
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              mode,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic                              in_last,
   input  logic [INPUT_SIZE*DATA_WIDTH-1:0]  data_in,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic                              out_partial,
   output logic [OUTPUT_SIZE*DATA_WIDTH-1:0] data_out
);

   // Two bits cover row indices 0..3 for the legal kernel sizes.
   localparam int                CNT_W    = 2;
   localparam logic [CNT_W-1:0]  LAST_ROW = CNT_W'(KERNEL_SIZE - 1);

   logic [CNT_W-1:0]                   row_cnt_q,     row_cnt_d;
   pool_mode_e                         mode_q,        mode_d;
   logic [DATA_WIDTH-1:0]              acc_q [OUTPUT_SIZE];
   logic [DATA_WIDTH-1:0]              acc_d [OUTPUT_SIZE];
   logic                               out_valid_q,   out_valid_d;
   logic                               out_partial_q, out_partial_d;
   logic [OUTPUT_SIZE*DATA_WIDTH-1:0]  data_out_q,    data_out_d;

   logic [DATA_WIDTH-1:0]              lane_in  [INPUT_SIZE];
   logic [DATA_WIDTH-1:0]              horz     [OUTPUT_SIZE];
   logic [DATA_WIDTH-1:0]              vert_sel [OUTPUT_SIZE];
   logic [DATA_WIDTH-1:0]              vert     [OUTPUT_SIZE];
   logic [OUTPUT_SIZE*DATA_WIDTH-1:0]  result_flat;

   logic       first_row;
   logic       in_fire;
   logic       out_fire;
   logic       close_win;
   pool_mode_e eff_mode;

   assign first_row = (row_cnt_q == '0);
   // The first row of a window uses the live mode so it can be applied in the
   // same cycle it is latched; later rows ignore mode changes.
   assign eff_mode  = first_row ? pool_mode_e'(mode) : mode_q;

   assign in_ready  = !(out_valid_q && !out_ready);
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid_q && out_ready;
   assign close_win = in_fire && ((row_cnt_q == LAST_ROW) || in_last);

   for (genvar i = 0; i < INPUT_SIZE; i++) begin : g_unpack
      assign lane_in[i] = data_in[(INPUT_SIZE-1-i)*DATA_WIDTH +: DATA_WIDTH];
   end

   for (genvar j = 0; j < OUTPUT_SIZE; j++) begin : g_lane
      logic [DATA_WIDTH-1:0] chain [KERNEL_SIZE];

      // Linear select chain; with K <= 4 the depth stays at three selects.
      assign chain[0] = lane_in[j*KERNEL_SIZE];
      for (genvar k = 1; k < KERNEL_SIZE; k++) begin : g_horz
         pooling_sel2 u_sel_h (
            .mode_i (eff_mode),
            .a_i    (chain[k-1]),
            .b_i    (lane_in[j*KERNEL_SIZE+k]),
            .y_o    (chain[k])
         );
      end
      assign horz[j] = chain[KERNEL_SIZE-1];

      pooling_sel2 u_sel_v (
         .mode_i (eff_mode),
         .a_i    (acc_q[j]),
         .b_i    (horz[j]),
         .y_o    (vert_sel[j])
      );

      assign vert[j] = first_row ? horz[j] : vert_sel[j];
      assign result_flat[(OUTPUT_SIZE-1-j)*DATA_WIDTH +: DATA_WIDTH] = vert[j];
   end

   always_comb begin
      row_cnt_d     = row_cnt_q;
      mode_d        = mode_q;
      acc_d         = acc_q;
      out_valid_d   = out_valid_q;
      out_partial_d = out_partial_q;
      data_out_d    = data_out_q;

      if (in_fire) begin
         acc_d = vert;
         if (first_row) begin
            mode_d = eff_mode;
         end
         row_cnt_d = close_win ? '0 : row_cnt_q + CNT_W'(1);
      end

      // A close wins over a draining handshake so back-to-back windows leave
      // no bubble on the output.
      if (close_win) begin
         out_valid_d   = 1'b1;
         data_out_d    = result_flat;
         out_partial_d = (row_cnt_q != LAST_ROW);
      end else if (out_fire) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         row_cnt_q     <= '0;
         mode_q        <= POOL_MAX;
         out_valid_q   <= 1'b0;
         out_partial_q <= 1'b0;
         data_out_q    <= '0;
         for (int j = 0; j < OUTPUT_SIZE; j++) begin
            acc_q[j] <= '0;
         end
      end else begin
         row_cnt_q     <= row_cnt_d;
         mode_q        <= mode_d;
         out_valid_q   <= out_valid_d;
         out_partial_q <= out_partial_d;
         data_out_q    <= data_out_d;
         acc_q         <= acc_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_partial = out_partial_q;
   assign data_out    = data_out_q;

endmodule

// File: tb/tb_pooling_stream_unit.sv
module tb_pooling_stream_unit;

   localparam int K = 2;
   localparam int O = 3;
   localparam int I = O * K;
   localparam int W = 32;

   localparam logic [I*W-1:0] ROW0 = {32'h3F800000, 32'h40000000, 32'hC0400000,
                                      32'h40400000, 32'h00000000, 32'h80000000};
   localparam logic [I*W-1:0] ROW1 = {32'h3F000000, 32'h3F000000, 32'h40800000,
                                      32'hBF800000, 32'h80000000, 32'hBF800000};
   localparam logic [O*W-1:0] MAX_EXP = {32'h40000000, 32'h40800000, 32'h00000000};
   localparam logic [O*W-1:0] MIN_EXP = {32'h3F000000, 32'hC0400000, 32'hBF800000};

   logic           clk = 1'b0;
   logic           rst_n;
   logic           mode;
   logic           in_valid;
   logic           in_ready;
   logic           in_last;
   logic [I*W-1:0] data_in;
   logic           out_valid;
   logic           out_ready;
   logic           out_partial;
   logic [O*W-1:0] data_out;

   pooling_stream_unit #(.OUTPUT_SIZE(O), .KERNEL_SIZE(K)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mode        (mode),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_last     (in_last),
      .data_in     (data_in),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_partial (out_partial),
      .data_out    (data_out)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: map each fp32 pattern to an unsigned key whose natural
   // order is the fp32 total order, then reduce whole windows.
   function automatic logic [31:0] ord_key(input logic [31:0] x);
      return x[31] ? ~x : {1'b1, x[30:0]};
   endfunction

   function automatic logic [31:0] msel(input bit mn, input logic [31:0] a, input logic [31:0] b);
      if (mn) return (ord_key(b) < ord_key(a)) ? b : a;
      return (ord_key(b) > ord_key(a)) ? b : a;
   endfunction

   function automatic logic [31:0] lane_of(input logic [I*W-1:0] d, input int i);
      return d[(I-1-i)*W +: W];
   endfunction

   logic [31:0]    m_acc [O];
   int             m_rows = 0;
   bit             m_mode = 0;
   int             n_exp  = 0;
   logic [O*W-1:0] exp_d [$];
   bit             exp_p [$];

   task automatic model_row(input logic [I*W-1:0] d, input bit last, input bit md, output bit closed);
      logic [31:0]    v;
      logic [O*W-1:0] packed_res;
      if (m_rows == 0) m_mode = md;
      for (int j = 0; j < O; j++) begin
         v = lane_of(d, j*K);
         for (int k = 1; k < K; k++) v = msel(m_mode, v, lane_of(d, j*K+k));
         m_acc[j] = (m_rows == 0) ? v : msel(m_mode, m_acc[j], v);
      end
      m_rows++;
      closed = (m_rows == K) || last;
      if (closed) begin
         for (int j = 0; j < O; j++) packed_res[(O-1-j)*W +: W] = m_acc[j];
         exp_d.push_back(packed_res);
         exp_p.push_back(m_rows < K);
         n_exp++;
         m_rows = 0;
      end
   endtask

   // out_ready: 0 = held low, 1 = held high, 2 = random
   int rdy_ctl = 1;
   always @(posedge clk) begin
      #1;
      case (rdy_ctl)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
   end

   // Output monitor / scoreboard, sampling on the falling edge.
   bit             prev_stall = 0;
   logic [O*W-1:0] prev_d;
   logic           prev_p;
   int             n_out = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
         if (prev_stall) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", data_out, prev_d);
            chk("hold_partial", out_partial, prev_p);
         end
         if (out_valid && out_ready) begin
            if (exp_d.size() == 0) begin
               chk("spurious_out", 1, 0);
            end else begin
               chk("data_out", data_out, exp_d.pop_front());
               chk("out_partial", out_partial, exp_p.pop_front());
               n_out++;
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_d     = data_out;
         prev_p     = out_partial;
      end else begin
         prev_stall = 0;
      end
   end

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send_row(input logic [I*W-1:0] d, input bit last, input bit md);
      int n;
      bit closed;
      in_valid = 1'b1;
      data_in  = d;
      in_last  = last;
      mode     = md;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         chk("accept_timeout", 0, 1);
         in_valid = 1'b0;
         in_last  = 1'b0;
         return;
      end
      model_row(d, last, md, closed);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (closed) chk("latency_valid", out_valid, 1);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_d.size() != 0 || out_valid) && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_queue", exp_d.size(), 0);
   endtask

   function automatic logic [I*W-1:0] rand_row();
      logic [I*W-1:0] r;
      logic [31:0]    v;
      for (int i = 0; i < I; i++) begin
         case ($urandom_range(0, 7))
            0:       v = 32'h00000000;
            1:       v = 32'h80000000;
            2:       v = 32'h7FC00000;
            3:       v = 32'hFFC00000;
            4:       v = {$urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, 8'h7F, 23'($urandom_range(0, 7))};
            default: v = $urandom;
         endcase
         r[(I-1-i)*W +: W] = v;
      end
      return r;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  r;
      bit  last;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      mode     = 1'b0;
      data_in  = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_partial", out_partial, 0);
      chk("rst_data_out", data_out, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_in_ready", in_ready, 1);
      chk("post_rst_out_valid", out_valid, 0);

      // Directed max / min on the reference rows.
      send_row(ROW0, 0, 0);
      send_row(ROW1, 0, 0);
      chk("dir_max_data", data_out, MAX_EXP);
      chk("dir_max_partial", out_partial, 0);
      send_row(ROW0, 0, 1);
      send_row(ROW1, 0, 1);
      chk("dir_min_data", data_out, MIN_EXP);

      // Early flush on row 0.
      send_row(ROW0, 1, 0);
      chk("flush_partial", out_partial, 1);
      chk("flush_lane0", data_out[O*W-1 -: W], 32'h40000000);

      // Mode toggled on row 1 must be ignored.
      send_row(ROW0, 0, 0);
      send_row(ROW1, 0, 1);
      chk("latch_max", data_out, MAX_EXP);
      wait_drain();

      // Backpressure: hold out_ready low for 5 cycles with a row waiting.
      rdy_ctl = 0;
      @(posedge clk);
      #1;
      send_row(ROW0, 0, 1);
      send_row(ROW1, 1, 1);
      in_valid = 1'b1;
      data_in  = ROW1;
      in_last  = 1'b1;
      mode     = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_out_valid", out_valid, 1);
         chk("bp_data", data_out, MIN_EXP);
      end
      rdy_ctl = 1;
      send_row(ROW1, 1, 0);
      wait_drain();

      // Reset in the middle of a window.
      send_row(ROW1, 0, 0);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_valid_during", out_valid, 0);
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      m_rows = 0;
      chk("midrst_valid_after", out_valid, 0);
      chk("midrst_in_ready", in_ready, 1);
      send_row(ROW0, 0, 1);
      send_row(ROW1, 0, 1);
      chk("midrst_result", data_out, MIN_EXP);
      wait_drain();

      // Random windows under random backpressure.
      rdy_ctl = 2;
      for (int w = 0; w < 100; w++) begin
         r = $urandom_range(1, K);
         for (int i = 0; i < r; i++) begin
            if ($urandom_range(0, 3) == 0) begin
               @(posedge clk);
               #1;
            end
            if (i == r - 1) last = (r < K) ? 1'b1 : ($urandom_range(0, 1) == 1);
            else            last = 1'b0;
            send_row(rand_row(), last, $urandom_range(0, 1) == 1);
         end
      end
      rdy_ctl = 1;
      wait_drain();
      chk("out_count", n_out, n_exp);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
